// File: rtl/simple_alu_pipe.sv
// simple_alu_pipe: pipelined RV64I/RV32I integer ALU with valid/ready handshake,
// flush and an illegal-op flag; an opaque tag travels with each result to writeback.
module simple_alu_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int IMM_W  = 32,
  parameter int TAG_W  = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       fn3_i,
  input  logic [6:0]       fn7_i,
  input  logic [5:0]       shamt_i,
  input  logic [XLEN-1:0]  data1_i,
  input  logic [XLEN-1:0]  data2_i,
  input  logic [IMM_W-1:0] immd_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             destValid_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             executed_o,
  output logic             destValid_o,
  output logic             exception_o
);

  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [6:0] {
    OPC_LUI       = 7'b0110111,
    OPC_AUIPC     = 7'b0010111,
    OPC_OP_IMM    = 7'b0010011,
    OPC_OP        = 7'b0110011,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_OP_32     = 7'b0111011
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic             dest_valid;
    logic             exception;
  } stage_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] res_c;
  logic            ill_c;

  // NOTE: every variable gets a default at the top of an always_comb so no path infers a latch.
  always_comb begin
    imm_x = XLEN'($signed(immd_i));
    res_c = '0;
    ill_c = 1'b0;
    case (opcode_i)
      OPC_LUI:   res_c = imm_x;
      OPC_AUIPC: res_c = pc_i + imm_x;
      OPC_OP_IMM: begin
        case (fn3_i)
          3'b000: res_c = data1_i + imm_x;
          3'b010: res_c = XLEN'($signed(data1_i) < $signed(imm_x));
          3'b011: res_c = XLEN'(data1_i < imm_x);
          3'b100: res_c = data1_i ^ imm_x;
          3'b110: res_c = data1_i | imm_x;
          3'b111: res_c = data1_i & imm_x;
          3'b001: begin
            if (fn7_i[6:1] != 6'h00 || ((XLEN == 32) && shamt_i[5])) ill_c = 1'b1;
            else res_c = data1_i << shamt_i[SH_W-1:0];
          end
          default: begin
            // fn7 bit 0 is shamt[5] in RV64, so only fn7[6:1] selects SRLI/SRAI
            if ((XLEN == 32) && shamt_i[5]) ill_c = 1'b1;
            else if (fn7_i[6:1] == 6'h00) res_c = data1_i >> shamt_i[SH_W-1:0];
            else if (fn7_i[6:1] == 6'h10) res_c = $signed(data1_i) >>> shamt_i[SH_W-1:0];
            else ill_c = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        if (fn7_i == 7'h00) begin
          case (fn3_i)
            3'b000:  res_c = data1_i + data2_i;
            3'b001:  res_c = data1_i << data2_i[SH_W-1:0];
            3'b010:  res_c = XLEN'($signed(data1_i) < $signed(data2_i));
            3'b011:  res_c = XLEN'(data1_i < data2_i);
            3'b100:  res_c = data1_i ^ data2_i;
            3'b101:  res_c = data1_i >> data2_i[SH_W-1:0];
            3'b110:  res_c = data1_i | data2_i;
            default: res_c = data1_i & data2_i;
          endcase
        end else if (fn7_i == 7'h20 && fn3_i == 3'b000) res_c = data1_i - data2_i;
        else if (fn7_i == 7'h20 && fn3_i == 3'b101) res_c = $signed(data1_i) >>> data2_i[SH_W-1:0];
        else ill_c = 1'b1;
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64) ill_c = 1'b1;
        else begin
          case (fn3_i)
            3'b000: res_c = sext32(data1_i[31:0] + imm_x[31:0]);
            3'b001: begin
              if (fn7_i[6:1] != 6'h00 || shamt_i[5]) ill_c = 1'b1;
              else res_c = sext32(data1_i[31:0] << shamt_i[4:0]);
            end
            3'b101: begin
              if (shamt_i[5]) ill_c = 1'b1;
              else if (fn7_i[6:1] == 6'h00) res_c = sext32(data1_i[31:0] >> shamt_i[4:0]);
              else if (fn7_i[6:1] == 6'h10) res_c = sext32($signed(data1_i[31:0]) >>> shamt_i[4:0]);
              else ill_c = 1'b1;
            end
            default: ill_c = 1'b1;
          endcase
        end
      end
      OPC_OP_32: begin
        if (XLEN != 64) ill_c = 1'b1;
        else if (fn7_i == 7'h00 && fn3_i == 3'b000) res_c = sext32(data1_i[31:0] + data2_i[31:0]);
        else if (fn7_i == 7'h00 && fn3_i == 3'b001) res_c = sext32(data1_i[31:0] << data2_i[4:0]);
        else if (fn7_i == 7'h00 && fn3_i == 3'b101) res_c = sext32(data1_i[31:0] >> data2_i[4:0]);
        else if (fn7_i == 7'h20 && fn3_i == 3'b000) res_c = sext32(data1_i[31:0] - data2_i[31:0]);
        else if (fn7_i == 7'h20 && fn3_i == 3'b101) res_c = sext32($signed(data1_i[31:0]) >>> data2_i[4:0]);
        else ill_c = 1'b1;
      end
      default: ill_c = 1'b1;
    endcase
    if (ill_c) res_c = '0;
  end

  logic [STAGES-1:0] vld_q, vld_d, vld_in, take;
  stage_t            stg_q  [STAGES];
  stage_t            stg_d  [STAGES];
  stage_t            stg_in [STAGES];

  always_comb begin
    logic nxt;
    // A stage can load when it is empty or its contents move on this cycle.
    nxt = ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      take[k] = ~vld_q[k] | nxt;
      nxt     = take[k];
    end
    ready_o = take[0];

    vld_in[0]            = valid_i;
    stg_in[0].result     = res_c;
    stg_in[0].tag        = tag_i;
    stg_in[0].dest_valid = destValid_i & ~ill_c;
    stg_in[0].exception  = ill_c;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      stg_in[k] = stg_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = take[k] ? vld_in[k] : vld_q[k];
      stg_d[k] = (take[k] && vld_in[k]) ? stg_in[k] : stg_q[k];
    end
    if (flush_i) vld_d = '0;
  end

  // NOTE: state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      // NOTE: stage data is reset too, so result_o/tag_o read 0 out of reset.
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      stg_q <= stg_d;
    end
  end

  assign valid_o     = vld_q[STAGES-1];
  assign executed_o  = vld_q[STAGES-1];
  assign result_o    = stg_q[STAGES-1].result;
  assign tag_o       = stg_q[STAGES-1].tag;
  assign destValid_o = stg_q[STAGES-1].dest_valid;
  assign exception_o = stg_q[STAGES-1].exception;

endmodule

// File: tb/tb_simple_alu_pipe.sv
// Scoreboard bench for simple_alu_pipe: directed ops push expected results, an
// independent monitor pops and compares each result handed to writeback.
module tb_simple_alu_pipe;
  localparam int XLEN   = 64;
  localparam int STAGES = 2;
  localparam int IMM_W  = 32;
  localparam int TAG_W  = 24;

  logic             clk, reset, flush_i, valid_i, ready_o, ready_i;
  logic [6:0]       opcode_i, fn7_i;
  logic [2:0]       fn3_i;
  logic [5:0]       shamt_i;
  logic [XLEN-1:0]  data1_i, data2_i, pc_i, result_o;
  logic [IMM_W-1:0] immd_i;
  logic             destValid_i, valid_o, executed_o, destValid_o, exception_o;
  logic [TAG_W-1:0] tag_i, tag_o;

  simple_alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .IMM_W(IMM_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .opcode_i(opcode_i), .fn3_i(fn3_i), .fn7_i(fn7_i), .shamt_i(shamt_i),
    .data1_i(data1_i), .data2_i(data2_i), .immd_i(immd_i), .pc_i(pc_i),
    .destValid_i(destValid_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .tag_o(tag_o), .executed_o(executed_o),
    .destValid_o(destValid_o), .exception_o(exception_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    logic             dv;
    logic             exc;
  } exp_t;

  exp_t             sb [$];
  exp_t             mon_e;
  int               checks = 0;
  int               errors = 0;
  logic [TAG_W-1:0] tag_cnt = 24'h000100;
  int               lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [5:0] sh, input logic [63:0] d1, input logic [63:0] d2,
                       input logic [31:0] imm, input logic [63:0] pc, input logic dv);
    opcode_i = op; fn3_i = f3; fn7_i = f7; shamt_i = sh;
    data1_i = d1; data2_i = d2; immd_i = imm; pc_i = pc;
    destValid_i = dv; tag_i = tag_cnt; valid_i = 1'b1;
  endtask

  // Offers one op, waits (bounded) for acceptance, then records the expected result.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [5:0] sh, input logic [63:0] d1, input logic [63:0] d2,
                      input logic [31:0] imm, input logic [63:0] pc, input logic dv,
                      input logic [63:0] res, input logic exc);
    logic acc;
    int   n;
    exp_t e;
    drive(op, f3, f7, sh, d1, d2, imm, pc, dv);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready_o stayed 0 for tag %h, required 1", tag_cnt);
    end else begin
      e.res = exc ? 64'h0 : res;
      e.tag = tag_cnt;
      e.dv  = dv & ~exc;
      e.exc = exc;
      sb.push_back(e);
    end
    tag_cnt++;
    valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && valid_o && ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result %h tag %h with nothing outstanding", result_o, tag_o);
        end else begin
          mon_e = sb.pop_front();
          check("result", result_o, mon_e.res);
          check("tag", 64'(tag_o), 64'(mon_e.tag));
          check("exception", 64'(exception_o), 64'(mon_e.exc));
          check("dest_valid", 64'(destValid_o), 64'(mon_e.dv));
          check("executed", 64'(executed_o), 64'd1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    opcode_i = '0; fn3_i = '0; fn7_i = '0; shamt_i = '0;
    data1_i = '0; data2_i = '0; immd_i = '0; pc_i = '0; destValid_i = 1'b0; tag_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_result_o", result_o, 64'd0);
    check("rst_tag_o", 64'(tag_o), 64'd0);
    check("rst_executed_o", 64'(executed_o), 64'd0);
    check("rst_destvalid_o", 64'(destValid_o), 64'd0);
    check("rst_exception_o", 64'(exception_o), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(ready_o), 64'd1);
    @(posedge clk); #1;

    // Latency: ADD 5+7 appears STAGES cycles after the issue cycle
    send(7'h33, 3'b000, 7'h00, 6'd0, 64'd5, 64'd7, 32'd0, 64'd0, 1'b1, 64'd12, 1'b0);
    lat = 0;
    repeat (10) begin
      @(negedge clk);
      lat++;
      if (valid_o) break;
    end
    check("latency", 64'(lat), 64'(STAGES));
    @(posedge clk); #1;
    wait_drain("latency_drain");

    // Back-to-back directed vectors
    send(7'h1B, 3'b000, 7'h00, 6'd0,  64'h7FFFFFFF, 64'd0, 32'd1, 64'd0, 1'b1, 64'hFFFFFFFF80000000, 1'b0); // ADDIW
    send(7'h13, 3'b101, 7'h21, 6'd63, 64'h8000000000000000, 64'd0, 32'd0, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0); // SRAI
    send(7'h13, 3'b010, 7'h00, 6'd0,  64'hFFFFFFFFFFFFFFFF, 64'd0, 32'd0, 64'd0, 1'b1, 64'd1, 1'b0); // SLTI
    send(7'h13, 3'b011, 7'h00, 6'd0,  64'd1, 64'd0, 32'hFFFFFFFF, 64'd0, 1'b1, 64'd1, 1'b0); // SLTIU
    send(7'h33, 3'b000, 7'h20, 6'd0,  64'd3, 64'd5, 32'd0, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b0); // SUB dv=0
    send(7'h3B, 3'b000, 7'h20, 6'd0,  64'h100000000, 64'd1, 32'd0, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0); // SUBW
    send(7'h3B, 3'b101, 7'h20, 6'd0,  64'h80000000, 64'd4, 32'd0, 64'd0, 1'b1, 64'hFFFFFFFFF8000000, 1'b0); // SRAW
    send(7'h3B, 3'b101, 7'h00, 6'd0,  64'h80000000, 64'd4, 32'd0, 64'd0, 1'b1, 64'h0000000008000000, 1'b0); // SRLW
    send(7'h33, 3'b001, 7'h00, 6'd0,  64'd1, 64'h41, 32'd0, 64'd0, 1'b1, 64'd2, 1'b0); // SLL
    send(7'h37, 3'b000, 7'h00, 6'd0,  64'd0, 64'd0, 32'h80000000, 64'd0, 1'b1, 64'hFFFFFFFF80000000, 1'b0); // LUI
    send(7'h17, 3'b000, 7'h00, 6'd0,  64'd0, 64'd0, 32'h2000, 64'h1000, 1'b1, 64'h3000, 1'b0); // AUIPC
    send(7'h13, 3'b100, 7'h00, 6'd0,  64'hFF, 64'd0, 32'hFFFFFFFF, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF00, 1'b0); // XORI
    send(7'h33, 3'b010, 7'h00, 6'd0,  64'hFFFFFFFFFFFFFFFE, 64'd1, 32'd0, 64'd0, 1'b1, 64'd1, 1'b0); // SLT
    send(7'h33, 3'b011, 7'h00, 6'd0,  64'hFFFFFFFFFFFFFFFE, 64'd1, 32'd0, 64'd0, 1'b1, 64'd0, 1'b0); // SLTU
    send(7'h13, 3'b101, 7'h01, 6'd63, 64'h8000000000000000, 64'd0, 32'd0, 64'd0, 1'b1, 64'd1, 1'b0); // SRLI
    send(7'h1B, 3'b001, 7'h00, 6'd31, 64'd1, 64'd0, 32'd0, 64'd0, 1'b1, 64'hFFFFFFFF80000000, 1'b0); // SLLIW
    send(7'h1B, 3'b101, 7'h20, 6'd4,  64'h80000000, 64'd0, 32'd0, 64'd0, 1'b1, 64'hFFFFFFFFF8000000, 1'b0); // SRAIW
    send(7'h3B, 3'b000, 7'h00, 6'd0,  64'hFFFFFFFF, 64'd1, 32'd0, 64'd0, 1'b1, 64'd0, 1'b0); // ADDW wrap
    send(7'h13, 3'b111, 7'h00, 6'd0,  64'h1234, 64'd0, 32'hF0, 64'd0, 1'b1, 64'h30, 1'b0); // ANDI
    send(7'h1B, 3'b001, 7'h01, 6'h20, 64'd1, 64'd0, 32'd0, 64'd0, 1'b1, 64'd0, 1'b1); // SLLIW shamt[5] illegal
    send(7'h7F, 3'b000, 7'h00, 6'd0,  64'd1, 64'd2, 32'd0, 64'd0, 1'b1, 64'd0, 1'b1); // unknown opcode
    send(7'h33, 3'b000, 7'h01, 6'd0,  64'd3, 64'd4, 32'd0, 64'd0, 1'b1, 64'd0, 1'b1); // MUL unsupported
    wait_drain("vector_drain");

    // Backpressure: writeback stalls while four ops are offered
    ready_i = 1'b0;
    fork
      for (int i = 1; i <= 4; i++)
        send(7'h13, 3'b000, 7'h00, 6'd0, 64'(i * 10), 64'd0, 32'(i), 64'd0, 1'b1, 64'(i * 11), 1'b0);
      begin
        repeat (5) @(negedge clk);
        check("stall_ready_o", 64'(ready_o), 64'd0);
        check("stall_valid_o", 64'(valid_o), 64'd1);
        check("stall_result_held", result_o, 64'd11);
        @(posedge clk); #1 ready_i = 1'b1;
      end
    join
    wait_drain("stall_drain");

    // Flush with two ops in flight and a third offered in the flush cycle
    ready_i = 1'b0;
    drive(7'h33, 3'b000, 7'h00, 6'd0, 64'd1, 64'd1, 32'd0, 64'd0, 1'b1);
    @(posedge clk); #1;
    tag_cnt++;
    drive(7'h33, 3'b000, 7'h00, 6'd0, 64'd2, 64'd2, 32'd0, 64'd0, 1'b1);
    @(posedge clk); #1;
    tag_cnt++;
    drive(7'h33, 3'b000, 7'h00, 6'd0, 64'd3, 64'd3, 32'd0, 64'd0, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    check("pre_flush_valid_o", 64'(valid_o), 64'd1);
    @(posedge clk); #1;
    tag_cnt++;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("flush_valid_o", 64'(valid_o), 64'd0);
    @(posedge clk); #1 ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_no_output", 64'(valid_o), 64'd0);
    end
    @(posedge clk); #1;

    send(7'h33, 3'b000, 7'h00, 6'd0, 64'd1, 64'd1, 32'd0, 64'd0, 1'b1, 64'd2, 1'b0);
    wait_drain("post_flush_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
